// File: rtl/tcam_route_loader_if.sv
// Host-side entry-loading channel of the TCAM route loader: entry handshake,
// table control strobes and loader status.
interface tcam_route_loader_if #(
    parameter int ID_Width    = 4,
    parameter int AddressSize = 4
);
    logic                   flush_req;
    logic                   commit;
    logic                   entry_valid;
    logic                   entry_ready;
    logic [ID_Width-1:0]    entry_src_id;
    logic [ID_Width-1:0]    entry_care;
    logic [ID_Width-1:0]    entry_dst_id;
    logic [AddressSize:0]   entry_count;
    logic                   table_full;
    logic                   table_ready;

    modport master (
        output flush_req, commit, entry_valid, entry_src_id, entry_care, entry_dst_id,
        input  entry_ready, entry_count, table_full, table_ready
    );

    modport slave (
        input  flush_req, commit, entry_valid, entry_src_id, entry_care, entry_dst_id,
        output entry_ready, entry_count, table_full, table_ready
    );
endinterface

// File: rtl/tcam_route_loader.sv
// Loads host routing entries into the TCAM: flush, spaced write/gap per entry,
// then hold the memory in compare mode for packet lookup.
module tcam_route_loader #(
    parameter int ID_Width    = 4,
    parameter int AddressSize = 4,
    parameter int Bits        = 8,
    parameter int Words       = 16,
    parameter int BankSize    = 1,
    parameter int FlushCycles = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tcam_route_loader_if.slave     host,
    output logic                   o_CS,
    output logic                   o_FLUSH,
    output logic                   o_VBE,
    output logic                   o_DCS,
    output logic                   o_WR,
    output logic                   o_VBI,
    output logic                   o_CMP_In,
    output logic [Bits-1:0]        o_Data_In,
    output logic [Bits-1:0]        o_Mask_In,
    output logic [BankSize-1:0]    o_CBE,
    output logic [AddressSize-1:0] o_Addr_In
);

    localparam int                   FCW       = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
    localparam logic [FCW-1:0]       FCNT_LAST = FCW'(FlushCycles - 1);
    localparam logic [AddressSize:0] WORDS_C   = (AddressSize + 1)'(Words);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_LOAD,
        S_WRITE,
        S_GAP,
        S_ACTIVE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [FCW-1:0]         r_fcnt;
    logic [AddressSize:0]   r_count;
    logic                   r_cs, r_flush, r_wr, r_cmp, r_tready;
    logic [BankSize-1:0]    r_cbe;
    logic [Bits-1:0]        r_data, r_mask;
    logic [AddressSize-1:0] r_addr;
    logic                   w_full, w_ready, w_accept, w_fcnt_clr;

    assign w_full   = (r_count == WORDS_C);
    assign w_ready  = (r_state == S_LOAD) && !w_full && !host.flush_req;
    assign w_accept = host.entry_valid && w_ready;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   w_next = S_FLUSH;
            S_FLUSH:  if (r_fcnt == FCNT_LAST) w_next = S_LOAD;
            S_LOAD: begin
                if (w_accept)         w_next = S_WRITE;
                else if (host.commit) w_next = S_ACTIVE;
            end
            S_WRITE:  w_next = S_GAP;
            S_GAP:    w_next = S_LOAD;
            S_ACTIVE: w_next = S_ACTIVE;
            default:  w_next = S_IDLE;
        endcase
        // A flush request restarts the table from any live state.
        if (r_state != S_IDLE && host.flush_req) w_next = S_FLUSH;
    end

    // Held flush_req keeps the flush counter at zero so the full flush
    // duration is always observed after the request drops.
    assign w_fcnt_clr = (w_next == S_FLUSH) && ((r_state != S_FLUSH) || host.flush_req);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_fcnt   <= '0;
            r_count  <= '0;
            r_cs     <= 1'b0;
            r_flush  <= 1'b0;
            r_wr     <= 1'b0;
            r_cmp    <= 1'b0;
            r_tready <= 1'b0;
            r_cbe    <= '0;
            r_data   <= '0;
            r_mask   <= '0;
            r_addr   <= '0;
        end else begin
            r_state  <= w_next;
            r_cs     <= (w_next == S_FLUSH) || (w_next == S_WRITE) || (w_next == S_ACTIVE);
            r_flush  <= (w_next == S_FLUSH);
            r_wr     <= (w_next == S_WRITE);
            r_cmp    <= (w_next == S_ACTIVE);
            r_tready <= (w_next == S_ACTIVE);
            r_cbe    <= ((w_next == S_FLUSH) || (w_next == S_WRITE) || (w_next == S_ACTIVE))
                        ? {BankSize{1'b1}} : {BankSize{1'b0}};

            if (w_fcnt_clr)
                r_fcnt <= '0;
            else if (r_state == S_FLUSH)
                r_fcnt <= r_fcnt + 1'b1;

            // The flush clear wins over the increment of an in-flight write.
            if (w_next == S_FLUSH)
                r_count <= '0;
            else if (r_state == S_WRITE)
                r_count <= r_count + 1'b1;

            if (w_accept) begin
                r_data <= {host.entry_src_id, host.entry_dst_id};
                r_mask <= {host.entry_care, {ID_Width{1'b1}}};
                r_addr <= r_count[AddressSize-1:0];
            end
        end
    end

    assign host.entry_ready = w_ready;
    assign host.entry_count = r_count;
    assign host.table_full  = w_full;
    assign host.table_ready = r_tready;

    assign o_CS      = r_cs;
    assign o_FLUSH   = r_flush;
    assign o_VBE     = r_wr;
    assign o_VBI     = r_wr;
    assign o_WR      = r_wr;
    assign o_DCS     = 1'b0;
    assign o_CMP_In  = r_cmp;
    assign o_CBE     = r_cbe;
    assign o_Data_In = r_data;
    assign o_Mask_In = r_mask;
    assign o_Addr_In = r_addr;

endmodule

// File: tb/tb_tcam_route_loader.sv
// Randomized scoreboard bench for tcam_route_loader: expected TCAM writes are
// queued at each handshake and checked by an independent write monitor.
module tb_tcam_route_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tcam_route_loader_if #(.ID_Width(4), .AddressSize(4)) hif ();

    logic       o_CS, o_FLUSH, o_VBE, o_DCS, o_WR, o_VBI, o_CMP_In;
    logic [7:0] o_Data_In, o_Mask_In;
    logic [0:0] o_CBE;
    logic [3:0] o_Addr_In;

    tcam_route_loader #(
        .ID_Width(4), .AddressSize(4), .Bits(8), .Words(16), .BankSize(1), .FlushCycles(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (hif),
        .o_CS      (o_CS),
        .o_FLUSH   (o_FLUSH),
        .o_VBE     (o_VBE),
        .o_DCS     (o_DCS),
        .o_WR      (o_WR),
        .o_VBI     (o_VBI),
        .o_CMP_In  (o_CMP_In),
        .o_Data_In (o_Data_In),
        .o_Mask_In (o_Mask_In),
        .o_CBE     (o_CBE),
        .o_Addr_In (o_Addr_In)
    );

    typedef struct {
        int         cyc;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] mask;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   model_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_assert++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Write monitor: every WR pulse must match the oldest queued handshake.
    always @(negedge clk) begin
        if (o_WR === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_cycle", cyc, mon_e.cyc);
                chk("wr_addr", {28'd0, o_Addr_In}, {28'd0, mon_e.addr});
                chk("wr_data", {24'd0, o_Data_In}, {24'd0, mon_e.data});
                chk("wr_mask", {24'd0, o_Mask_In}, {24'd0, mon_e.mask});
                chk("wr_ctrl", {25'd0, o_CS, o_VBE, o_VBI, o_DCS, o_CMP_In, o_FLUSH, o_CBE},
                    {25'd0, 7'b1110001});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {21'd0, o_CS, o_FLUSH, o_VBE, o_DCS, o_WR, o_VBI, o_CMP_In, o_CBE,
                           hif.entry_ready, hif.table_ready, hif.table_full}, 32'd0);
        chk({nm, "_dat"}, {o_Data_In, o_Mask_In, o_Addr_In, hif.entry_count[3:0]} , 32'd0);
        chk({nm, "_cnt"}, {27'd0, hif.entry_count}, 32'd0);
    endtask

    // Called in the first FLUSH cycle; returns in the first LOAD cycle.
    task automatic check_flush_seq(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk({nm, "_flush_ctl"}, {28'd0, o_FLUSH, o_CS, o_CBE, o_WR}, {28'd0, 4'b1110});
            chk({nm, "_flush_rdy"}, {30'd0, hif.entry_ready, o_CMP_In}, 32'd0);
            chk({nm, "_flush_cnt"}, {27'd0, hif.entry_count}, 32'd0);
            tick();
        end
        chk({nm, "_load_ctl"}, {29'd0, o_FLUSH, o_CS, o_CMP_In}, 32'd0);
        chk({nm, "_load_rdy"}, {31'd0, hif.entry_ready}, 32'd1);
    endtask

    task automatic send_entry(input logic [3:0] s, input logic [3:0] ca, input logic [3:0] d,
                              input logic with_commit, output int hs);
        exp_t e;
        bit   got;
        got = 0;
        hs  = -1;
        hif.entry_valid  = 1'b1;
        hif.entry_src_id = s;
        hif.entry_care   = ca;
        hif.entry_dst_id = d;
        hif.commit       = with_commit;
        #1;
        for (int i = 0; i < 12 && !got; i++) begin
            if (hif.entry_ready === 1'b1) begin
                got    = 1;
                hs     = cyc;
                e.cyc  = cyc + 1;
                e.addr = 4'(model_count);
                e.data = {s, d};
                e.mask = {ca, 4'hF};
                sb.push_back(e);
                model_count++;
            end else begin
                tick();
            end
        end
        if (got) tick();
        else chk("hs_timeout", 32'd0, 32'd1);
        hif.entry_valid = 1'b0;
        hif.commit      = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int hs, prev, highs;
        hif.flush_req    = 1'b0;
        hif.commit       = 1'b0;
        hif.entry_valid  = 1'b0;
        hif.entry_src_id = '0;
        hif.entry_care   = '0;
        hif.entry_dst_id = '0;

        // Reset, then the mandatory flush before loading.
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        chk_all_zero("idle");
        tick();
        check_flush_seq("boot");

        // Single write with known values.
        send_entry(4'hA, 4'hF, 4'h3, 1'b0, hs);
        chk("single_cnt_wr", {27'd0, hif.entry_count}, 32'd0);
        tick();
        chk("single_cnt", {27'd0, hif.entry_count}, 32'(model_count));
        chk("single_rdy_gap", {31'd0, hif.entry_ready}, 32'd0);
        tick();
        chk("single_rdy_back", {31'd0, hif.entry_ready}, 32'd1);

        // Flush from LOAD clears the count.
        hif.flush_req = 1'b1;
        #1;
        chk("flushreq_rdy", {31'd0, hif.entry_ready}, 32'd0);
        tick();
        hif.flush_req = 1'b0;
        model_count = 0;
        check_flush_seq("flush1");

        // Fill the table back to back with distinct random entries.
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            send_entry(4'(i), 4'($urandom), 4'($urandom), 1'b0, hs);
            if (i > 0) chk("b2b_spacing", 32'(hs - prev), 32'd3);
            prev = hs;
        end
        tick();
        tick();
        chk("full_cnt", {27'd0, hif.entry_count}, 32'(model_count));
        chk("full_flag", {30'd0, hif.table_full, hif.entry_ready}, {30'd0, 2'b10});
        hif.entry_valid  = 1'b1;
        hif.entry_src_id = 4'($urandom);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            if (hif.entry_ready !== 1'b0) highs++;
            tick();
        end
        chk("stall_ready", 32'(highs), 32'd0);
        chk("stall_cnt", {27'd0, hif.entry_count}, 32'd16);

        // Commit on a full table is still honoured.
        hif.commit = 1'b1;
        tick();
        hif.commit = 1'b0;
        hif.entry_valid = 1'b0;
        chk("commit_full", {27'd0, hif.table_ready, o_CMP_In, o_CS, o_WR, o_FLUSH},
            {27'd0, 5'b11100});

        // flush_req held for three cycles from ACTIVE.
        hif.flush_req = 1'b1;
        tick();
        chk("held_flush_a", {31'd0, o_FLUSH}, 32'd1);
        tick();
        chk("held_flush_b", {31'd0, o_FLUSH}, 32'd1);
        tick();
        hif.flush_req = 1'b0;
        model_count = 0;
        check_flush_seq("held");

        // Three entries; the third coincides with commit, which must be ignored.
        send_entry(4'($urandom), 4'($urandom), 4'($urandom), 1'b0, hs);
        send_entry(4'($urandom), 4'($urandom), 4'($urandom), 1'b0, hs);
        send_entry(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, hs);
        chk("commit_ignored", {30'd0, hif.table_ready, o_CMP_In}, 32'd0);
        tick();
        tick();
        hif.commit = 1'b1;
        tick();
        hif.commit = 1'b0;
        chk("commit_active", {27'd0, hif.table_ready, o_CMP_In, o_CS, o_WR, o_FLUSH},
            {27'd0, 5'b11100});
        chk("commit_cnt", {27'd0, hif.entry_count}, 32'(model_count));
        hif.entry_valid = 1'b1;
        highs = 0;
        for (int i = 0; i < 4; i++) begin
            if (hif.entry_ready !== 1'b0 || hif.table_ready !== 1'b1) highs++;
            tick();
        end
        hif.entry_valid = 1'b0;
        chk("active_hold", 32'(highs), 32'd0);

        // Flush raised in the WR cycle: write completes, count is discarded.
        hif.flush_req = 1'b1;
        tick();
        hif.flush_req = 1'b0;
        model_count = 0;
        check_flush_seq("flush2");
        send_entry(4'($urandom), 4'($urandom), 4'($urandom), 1'b0, hs);
        hif.flush_req = 1'b1;
        tick();
        hif.flush_req = 1'b0;
        model_count = 0;
        check_flush_seq("flush_wr");
        send_entry(4'($urandom), 4'($urandom), 4'($urandom), 1'b0, hs);
        tick();
        chk("after_flush_cnt", {27'd0, hif.entry_count}, 32'(model_count));
        tick();

        // Reset while ACTIVE.
        hif.commit = 1'b1;
        tick();
        hif.commit = 1'b0;
        chk("pre_reset_active", {31'd0, hif.table_ready}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk_all_zero("midreset");
        rst_n = 1'b1;
        model_count = 0;
        tick();
        check_flush_seq("reboot");

        tick();
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
